// File: rtl/link_sync_receiver_if.sv
// Port bundle for link_sync_receiver: dual-rail link rails and acknowledge, plus the
// valid/ready token stream and status. The receiver uses the master modport; the driver/consumer uses slave.
interface link_sync_receiver_if #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned RAIL_NUM = 2;
  localparam int unsigned CW       = $clog2(DEPTH + 1);

  logic [WIDTH-1:0][RAIL_NUM-1:0] in;
  logic                           ack_o;
  logic [WIDTH-1:0]               m_data;
  logic                           m_valid;
  logic                           m_ready;
  logic [CW-1:0]                  count;
  logic                           err;

  modport master (
    input  in, m_ready,
    output ack_o, m_data, m_valid, count, err
  );

  modport slave (
    output in, m_ready,
    input  ack_o, m_data, m_valid, count, err
  );
endinterface

// File: rtl/link_sync_receiver.sv
// Clocked sink for a two-phase dual-rail link: synchronises rails, detects token completion,
// acknowledges by toggling ack_o and buffers tokens in a first-word-fall-through FIFO.
module link_sync_receiver #(
  parameter string       ENC         = "TP",
  parameter int unsigned WIDTH       = 1,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  link_sync_receiver_if.master bus
);
  localparam int unsigned RAIL_NUM = 2;
  localparam int unsigned AW       = $clog2(DEPTH);
  localparam int unsigned CW       = $clog2(DEPTH + 1);

  if (ENC != "TP") begin : g_bad_enc
    $error("link_sync_receiver: unsupported link encoding");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("link_sync_receiver: DEPTH must be a power of two >= 2");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("link_sync_receiver: SYNC_STAGES must be >= 2");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    ERR  = 2'd2
  } state_t;

  state_t                                           r_state;
  logic [SYNC_STAGES-1:0][WIDTH-1:0][RAIL_NUM-1:0]  r_sync;
  logic [WIDTH-1:0][RAIL_NUM-1:0]                   r_ref;
  logic                                             r_ack;
  logic                                             r_err;
  logic [WIDTH-1:0]                                 r_mem [DEPTH];
  logic [AW-1:0]                                    r_wr_ptr;
  logic [AW-1:0]                                    r_rd_ptr;
  logic [CW-1:0]                                    r_count;
  logic                                             r_m_valid;
  logic [WIDTH-1:0]                                 r_m_data;

  logic [WIDTH-1:0][RAIL_NUM-1:0]                   w_s;
  logic [WIDTH-1:0]                                 w_d1;
  logic [WIDTH-1:0]                                 w_d0;
  logic                                             w_complete;
  logic                                             w_illegal;
  logic                                             w_full;
  logic                                             w_push;
  logic                                             w_pop;
  logic [CW-1:0]                                    w_count_nxt;

  // Rail synchroniser chain; the last stage is the only view of the link used by the logic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync[0] <= bus.in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1];

  // A rail differing from its reference has toggled since the last accepted token.
  always_comb begin
    w_d1 = '0;
    w_d0 = '0;
    for (int b = 0; b < WIDTH; b++) begin
      w_d1[b] = w_s[b][1] ^ r_ref[b][1];
      w_d0[b] = w_s[b][0] ^ r_ref[b][0];
    end
  end

  assign w_complete = &(w_d1 ^ w_d0);
  assign w_illegal  = |(w_d1 & w_d0);
  assign w_full     = (r_count >= CW'(DEPTH));
  assign w_pop      = r_m_valid && bus.m_ready;

  always_comb begin
    w_push = 1'b0;
    case (r_state)
      IDLE:    w_push = !w_illegal && w_complete && !w_full;
      HOLD:    w_push = !w_illegal && !w_full;
      default: w_push = 1'b0;
    endcase
  end

  assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

  // Link control: accept, hold on full, or latch a protocol error until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ref   <= '0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_illegal) begin
            r_state <= ERR;
            r_err   <= 1'b1;
          end else if (w_complete && w_full) begin
            r_state <= HOLD;
          end
        end
        HOLD: begin
          if (w_illegal) begin
            r_state <= ERR;
            r_err   <= 1'b1;
          end else if (!w_full) begin
            r_state <= IDLE;
          end
        end
        ERR: begin
          r_err <= 1'b1;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
      if (w_push) begin
        r_ref <= w_s;
        r_ack <= ~r_ack;
      end
    end
  end

  // Storage array carries no reset; contents are only observed through valid entries.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_d1;
    end
  end

  // Pointers, occupancy and the registered head-of-queue view.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count   <= w_count_nxt;
      r_m_valid <= (w_count_nxt != '0);
      if (w_pop && (r_count != CW'(1))) begin
        r_m_data <= r_mem[r_rd_ptr + AW'(1)];
      end else if (w_push && ((r_count == '0) || w_pop)) begin
        r_m_data <= w_d1;
      end
    end
  end

  assign bus.ack_o   = r_ack;
  assign bus.err     = r_err;
  assign bus.count   = r_count;
  assign bus.m_valid = r_m_valid;
  assign bus.m_data  = r_m_data;
endmodule
